// File: rtl/regf_operand_stage.sv
// 32x32 register file (r0 reads as zero) feeding a registered A/B operand latch with valid/ready handshake.
// Optional build macro REGF_BYPASS_EN forwards same-cycle write-back data into the latch.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no operand pair pending; any rd_req is accepted
// ST_FULL  | regf_data1/2 hold an unconsumed pair; refill only on consume
module regf_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] regf_data1,
  output logic [DATA_W-1:0] regf_data2,
  output logic              operand_valid,
  input  logic              operand_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_count
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rd_val1, rd_val2;
  logic              wr_commit;
  logic              latch_en;

  assign wr_commit = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
      wr_count      <= wr_count + 16'd1;
    end
  end

  // r0 is forced to zero on read; wr_commit already excludes address 0 from forwarding
  always_comb begin
    rd_val1 = (rs_addr == '0) ? '0 : regs[rs_addr];
    rd_val2 = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGF_BYPASS_EN
    if (wr_commit && (wr_addr == rs_addr)) rd_val1 = wr_data;
    if (wr_commit && (wr_addr == rt_addr)) rd_val2 = wr_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_ack    = 1'b0;
    latch_en  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (rd_req) begin
          rd_ack    = 1'b1;
          latch_en  = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (operand_ready) begin
          if (rd_req) begin
            rd_ack   = 1'b1;
            latch_en = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign operand_valid = (state == ST_FULL);

  // Data is held on drain so the ALU side sees stable values after consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regf_data1 <= '0;
      regf_data2 <= '0;
    end else if (latch_en) begin
      regf_data1 <= rd_val1;
      regf_data2 <= rd_val2;
    end
  end

endmodule

// File: tb/tb_regf_operand_stage.sv
// Self-checking bench for regf_operand_stage: directed scenarios then random traffic against a behavioural model.
// Honours REGF_BYPASS_EN the same way the design does, so it runs in either build.
module tb_regf_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [4:0]  rs_addr, rt_addr;
  logic        rd_ack;
  logic [31:0] regf_data1, regf_data2;
  logic        operand_valid;
  logic        operand_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  regf_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_ack(rd_ack), .regf_data1(regf_data1), .regf_data2(regf_data2),
    .operand_valid(operand_valid), .operand_ready(operand_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain array of register values plus the pending operand pair
  logic [31:0] m_regs [32];
  logic [15:0] m_count;
  logic        m_valid;
  logic [31:0] m_d1, m_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_count = '0;
    m_valid = 1'b0;
    m_d1    = '0;
    m_d2    = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef REGF_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  // One clock: drive at negedge, check rd_ack, step model at posedge, check outputs at next negedge
  task automatic cycle(input logic rq, input logic [4:0] rs, input logic [4:0] rt, input logic rdy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic        acc;
    logic [31:0] v1, v2;
    rd_req = rq; rs_addr = rs; rt_addr = rt; operand_ready = rdy;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    acc = m_valid ? (rq && rdy) : rq;
    chk("rd_ack", {31'd0, rd_ack}, {31'd0, acc});
    v1 = m_read(rs, we, wa, wd);
    v2 = m_read(rt, we, wa, wd);
    @(posedge clk);
    if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_count    = m_count + 16'd1;
    end
    if (acc) begin
      m_valid = 1'b1; m_d1 = v1; m_d2 = v2;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("operand_valid", {31'd0, operand_valid}, {31'd0, m_valid});
    chk("regf_data1", regf_data1, m_d1);
    chk("regf_data2", regf_data2, m_d2);
    chk("wr_count", {16'd0, wr_count}, {16'd0, m_count});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  logic [31:0] snap1, snap2, exp_byp;

  initial begin
    rst_n = 1'b0; rd_req = 0; rs_addr = 0; rt_addr = 0; operand_ready = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    model_reset();
    #12;
    chk("reset_valid", {31'd0, operand_valid}, 32'd0);
    chk("reset_data1", regf_data1, 32'd0);
    chk("reset_data2", regf_data2, 32'd0);
    chk("reset_count", {16'd0, wr_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first read: rs=3 rt=0 -> zeros, valid after one edge; then drain
    cycle(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("first_read_valid", {31'd0, operand_valid}, 32'd1);
    cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("drain_holds_data1", regf_data1, 32'd0);

    // write r5 then read rs=rt=5
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h0000_00A5);
    cycle(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r5_data1", regf_data1, 32'h0000_00A5);
    chk("r5_data2", regf_data2, 32'h0000_00A5);
    chk("r5_count", {16'd0, wr_count}, 32'd1);
    cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);

    // write to r0 is discarded
    cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r0_data1", regf_data1, 32'd0);
    chk("r0_count", {16'd0, wr_count}, 32'd1);
    cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);

    // same-cycle write and read of r7
`ifdef REGF_BYPASS_EN
    exp_byp = 32'h1234_5678;
`else
    exp_byp = 32'd0;
`endif
    cycle(1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    chk("same_cycle_r7", regf_data1, exp_byp);

    // FULL with ready low for 3 cycles: rd_req ignored, snapshot unaffected by writes to r7/r5
    snap1 = regf_data1; snap2 = regf_data2;
    cycle(1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 5'd7, 32'hCAFE_0007);
    cycle(1'b1, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 32'hBEEF_0005);
    chk("stall_data1", regf_data1, snap1);
    chk("stall_data2", regf_data2, snap2);
    cycle(1'b1, 5'd5, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("resume_data1", regf_data1, 32'hBEEF_0005);
    chk("resume_data2", regf_data2, 32'hCAFE_0007);

    // back-to-back pairs
    cycle(1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 5'd9, 32'h0000_0009);
    cycle(1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("b2b_r9", regf_data1, 32'h0000_0009);

    // async reset while FULL
    chk("pre_reset_valid", {31'd0, operand_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", {31'd0, operand_valid}, 32'd0);
    chk("async_count", {16'd0, wr_count}, 32'd0);
    chk("async_data1", regf_data1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 2)
      cycle(1'b1, 5'(i), 5'(i + 1), 1'b1, 1'b0, 5'd0, 32'd0);
    idle();
    cycle(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);

    // random traffic, addresses biased to a small window for collisions
    for (int n = 0; n < 600; n++) begin
      logic [4:0] ra, rb, wa;
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wa = ($urandom_range(0, 1) == 0) ? ra : 5'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 99) < 60), ra, rb, 1'($urandom_range(0, 99) < 60),
            1'($urandom_range(0, 99) < 50), wa, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
